// File: rtl/buffer_writeback.sv
`default_nettype none
// ============================================================================
// buffer_writeback : write-back FIFO from L2 dirty evictions to main memory,
// with same-address coalescing and forwarding to L2 miss lookups.  Rev 1.0
// ============================================================================
module buffer_writeback #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 4,
    parameter int MEM_LAT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   evict_valid,
    input  logic [ADDR_W-1:0]      evict_addr,
    input  logic [DATA_W-1:0]      evict_data,
    output logic                   evict_ready,
    input  logic [ADDR_W-1:0]      lookup_addr,
    output logic                   lookup_hit,
    output logic [DATA_W-1:0]      lookup_data,
    output logic                   mem_wren,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_lat_w = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_lat_w-1:0] c_lat_load = c_lat_w'(MEM_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [c_ptr_w-1:0]   head_q, head_d;
    logic [c_ptr_w-1:0]   tail_q, tail_d;
    logic [c_cnt_w-1:0]   count_q, count_d;
    logic [c_lat_w-1:0]   lat_q, lat_d;
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [ADDR_W-1:0]    addr_q [DEPTH];
    logic [ADDR_W-1:0]    addr_d [DEPTH];
    logic [DATA_W-1:0]    data_q [DEPTH];
    logic [DATA_W-1:0]    data_d [DEPTH];

    logic                 w_push;
    logic                 w_alloc;
    logic                 w_pop;
    logic                 w_co_hit;
    logic [c_ptr_w-1:0]   w_co_idx;

    assign evict_ready = (count_q != c_full);
    assign count       = count_q;
    assign empty       = (count_q == '0) && (state_q == S_IDLE);
    assign mem_wren    = (state_q == S_WRITE);
    assign mem_addr    = mem_wren ? addr_q[head_q] : '0;
    assign mem_wdata   = mem_wren ? data_q[head_q] : '0;

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        w_co_hit    = 1'b0;
        w_co_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[head_q + c_ptr_w'(i)] &&
                (addr_q[head_q + c_ptr_w'(i)] == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[head_q + c_ptr_w'(i)];
            end
            // The entry being written to memory must not change under the write.
            if (valid_q[head_q + c_ptr_w'(i)] &&
                (addr_q[head_q + c_ptr_w'(i)] == evict_addr) &&
                !((state_q == S_WRITE) && (i == 0))) begin
                w_co_hit = 1'b1;
                w_co_idx = head_q + c_ptr_w'(i);
            end
        end
    end

    assign w_push  = evict_valid && evict_ready;
    assign w_alloc = w_push && !w_co_hit;
    assign w_pop   = (state_q == S_WRITE) && (lat_q == '0);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        lat_d   = lat_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;

        if (w_push && w_co_hit) begin
            data_d[w_co_idx] = evict_data;
        end
        if (w_alloc) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = evict_addr;
            data_d[tail_q]  = evict_data;
            tail_d          = tail_q + c_ptr_one;
        end
        if (w_pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + c_ptr_one;
        end

        count_d = count_q + c_cnt_w'(w_alloc) - c_cnt_w'(w_pop);

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_WRITE;
                    lat_d   = c_lat_load;
                end
            end
            S_WRITE: begin
                if (lat_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    lat_d = lat_q - c_lat_w'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            lat_q   <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            lat_q   <= lat_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_buffer_writeback.sv
`default_nettype none
// ============================================================================
// tb_buffer_writeback : directed vector table plus multi-cycle sequences.
// Rev 1.0
// ============================================================================
module tb_buffer_writeback;

    logic        clk;
    logic        rst_n;
    logic        evict_valid;
    logic [5:0]  evict_addr;
    logic [15:0] evict_data;
    logic        evict_ready;
    logic [5:0]  lookup_addr;
    logic        lookup_hit;
    logic [15:0] lookup_data;
    logic        mem_wren;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        empty;
    logic [2:0]  count;

    buffer_writeback #(
        .ADDR_W (6),
        .DATA_W (16),
        .DEPTH  (4),
        .MEM_LAT(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .evict_valid(evict_valid),
        .evict_addr (evict_addr),
        .evict_data (evict_data),
        .evict_ready(evict_ready),
        .lookup_addr(lookup_addr),
        .lookup_hit (lookup_hit),
        .lookup_data(lookup_data),
        .mem_wren   (mem_wren),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .empty      (empty),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Memory-write log: one entry per rising edge of mem_wren.
    int   wa[$];
    int   wd[$];
    int   wc[$];
    int   wren_cycles = 0;
    int   maxcnt      = 0;
    logic prev_wren   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_wren && !prev_wren) begin
            wa.push_back(int'(mem_addr));
            wd.push_back(int'(mem_wdata));
            wc.push_back(cyc);
        end
        if (mem_wren) wren_cycles <= wren_cycles + 1;
        if (int'(count) > maxcnt) maxcnt <= int'(count);
        prev_wren <= mem_wren;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
        wren_cycles = 0;
        maxcnt      = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        evict_valid = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string name);
        int g;
        g = 0;
        while (!empty && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (!empty) chk(name, 0, 1);
    endtask

    typedef struct {
        int ev, ea, ed, la;
        int cnt, rdy, wren, ma, md, hit, ld, emp;
    } vec_t;

    vec_t vecs[16];
    int   acc_cyc[5];
    int   g;
    int   base;
    logic accepted;
    logic saw_full;

    initial begin
        // ev ea ed la | cnt rdy wren ma md hit ld emp
        vecs[0]  = '{1, 18,  4, 18,  0, 1, 0,  0,  0, 0,  0, 1};
        vecs[1]  = '{0,  0,  0, 18,  1, 1, 0,  0,  0, 1,  4, 0};
        vecs[2]  = '{0,  0,  0, 18,  1, 1, 1, 18,  4, 1,  4, 0};
        vecs[3]  = '{0,  0,  0, 18,  1, 1, 1, 18,  4, 1,  4, 0};
        vecs[4]  = '{0,  0,  0, 18,  1, 1, 1, 18,  4, 1,  4, 0};
        vecs[5]  = '{0,  0,  0, 18,  0, 1, 0,  0,  0, 0,  0, 1};
        vecs[6]  = '{1, 19, 19, 19,  0, 1, 0,  0,  0, 0,  0, 1};
        vecs[7]  = '{0,  0,  0, 19,  1, 1, 0,  0,  0, 1, 19, 0};
        vecs[8]  = '{1, 19,  7, 19,  1, 1, 1, 19, 19, 1, 19, 0};
        vecs[9]  = '{0,  0,  0, 19,  2, 1, 1, 19, 19, 1,  7, 0};
        vecs[10] = '{0,  0,  0, 20,  2, 1, 1, 19, 19, 0,  0, 0};
        vecs[11] = '{0,  0,  0, 19,  1, 1, 0,  0,  0, 1,  7, 0};
        vecs[12] = '{0,  0,  0, 19,  1, 1, 1, 19,  7, 1,  7, 0};
        vecs[13] = '{0,  0,  0, 19,  1, 1, 1, 19,  7, 1,  7, 0};
        vecs[14] = '{0,  0,  0, 19,  1, 1, 1, 19,  7, 1,  7, 0};
        vecs[15] = '{0,  0,  0, 19,  0, 1, 0,  0,  0, 0,  0, 1};

        // Reset values with busy-looking inputs applied.
        rst_n       = 1'b0;
        evict_valid = 1'b1;
        evict_addr  = 6'd5;
        evict_data  = 16'd5;
        lookup_addr = 6'd0;
        #12;
        chk("rst_ready", int'(evict_ready), 1);
        chk("rst_empty", int'(empty), 1);
        chk("rst_wren",  int'(mem_wren), 0);
        chk("rst_maddr", int'(mem_addr), 0);
        chk("rst_mdata", int'(mem_wdata), 0);
        chk("rst_hit",   int'(lookup_hit), 0);
        chk("rst_ldata", int'(lookup_data), 0);
        chk("rst_count", int'(count), 0);
        apply_reset();

        // Vector table: single write timing, then duplicate address vs in-flight write.
        for (int i = 0; i < 16; i++) begin
            evict_valid = vecs[i].ev[0];
            evict_addr  = 6'(vecs[i].ea);
            evict_data  = 16'(vecs[i].ed);
            lookup_addr = 6'(vecs[i].la);
            #1;
            chk($sformatf("v%0d_count", i), int'(count),       vecs[i].cnt);
            chk($sformatf("v%0d_ready", i), int'(evict_ready), vecs[i].rdy);
            chk($sformatf("v%0d_wren", i),  int'(mem_wren),    vecs[i].wren);
            chk($sformatf("v%0d_maddr", i), int'(mem_addr),    vecs[i].ma);
            chk($sformatf("v%0d_mdata", i), int'(mem_wdata),   vecs[i].md);
            chk($sformatf("v%0d_hit", i),   int'(lookup_hit),  vecs[i].hit);
            chk($sformatf("v%0d_ldata", i), int'(lookup_data), vecs[i].ld);
            chk($sformatf("v%0d_empty", i), int'(empty),       vecs[i].emp);
            @(posedge clk);
            #1;
        end
        evict_valid = 1'b0;

        // Five back-to-back evictions into a 4-deep buffer.
        apply_reset();
        clear_log();
        saw_full = 1'b0;
        for (int k = 0; k < 5; k++) begin
            evict_valid = 1'b1;
            evict_addr  = 6'(2 * k + 1);
            evict_data  = 16'(100 + k);
            accepted    = 1'b0;
            g           = 0;
            while (!accepted && g < 50) begin
                if (!evict_ready) begin
                    saw_full = 1'b1;
                    chk("full_count", int'(count), 4);
                end
                accepted = evict_ready;
                @(posedge clk);
                #1;
                g++;
            end
            if (!accepted) chk("accept_timeout", 0, 1);
            acc_cyc[k] = cyc;
        end
        evict_valid = 1'b0;
        chk("saw_full", int'(saw_full), 1);
        chk("fifth_accept_delay", acc_cyc[4] - acc_cyc[0], 5);
        chk("count_after_fifth", int'(count), 4);
        wait_empty("drain5_timeout");
        chk("drain5_nwrites", wa.size(), 5);
        if (wa.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("drain5_addr%0d", k), wa[k], 2 * k + 1);
                chk($sformatf("drain5_data%0d", k), wd[k], 100 + k);
                if (k > 0) chk($sformatf("drain5_gap%0d", k), wc[k] - wc[k-1], 4);
            end
        end
        chk("drain5_wren_cycles", wren_cycles, 15);

        // Coalescing behind an in-flight write.
        apply_reset();
        clear_log();
        evict_valid = 1'b1;
        evict_addr  = 6'd1;
        evict_data  = 16'd1;
        @(posedge clk);
        #1;
        evict_valid = 1'b0;
        g = 0;
        while (!mem_wren && g < 20) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("coal_write_started", int'(mem_wren), 1);
        evict_valid = 1'b1;
        evict_addr  = 6'd3;
        evict_data  = 16'd4;
        @(posedge clk);
        #1;
        evict_data = 16'd9;
        @(posedge clk);
        #1;
        evict_valid = 1'b0;
        wait_empty("coal_timeout");
        chk("coal_peak_count", maxcnt, 2);
        chk("coal_nwrites", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("coal_addr0", wa[0], 1);
            chk("coal_addr1", wa[1], 3);
            chk("coal_data1", wd[1], 9);
        end

        // Reset in the second WRITE cycle with three entries buffered.
        apply_reset();
        clear_log();
        lookup_addr = 6'd11;
        for (int k = 0; k < 3; k++) begin
            evict_valid = 1'b1;
            evict_addr  = 6'(10 + k);
            evict_data  = 16'(50 + k);
            @(posedge clk);
            #1;
        end
        evict_valid = 1'b0;
        chk("pre_rst_count", int'(count), 3);
        chk("pre_rst_wren", int'(mem_wren), 1);
        chk("pre_rst_hit", int'(lookup_hit), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wren",  int'(mem_wren), 0);
        chk("arst_maddr", int'(mem_addr), 0);
        chk("arst_mdata", int'(mem_wdata), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_ready", int'(evict_ready), 1);
        chk("arst_empty", int'(empty), 1);
        chk("arst_hit",   int'(lookup_hit), 0);
        chk("arst_ldata", int'(lookup_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        base = wa.size();
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_writes", wa.size(), base);
        chk("post_rst_count", int'(count), 0);
        chk("post_rst_empty", int'(empty), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
